// File: rtl/pkt_mem_loader_pkg.sv
// Shared definitions for the program-load snooper: FSM encoding, CMD field layout
// and the stream ctrl decode used by both the frame tracker and the load FSM.
package pkt_mem_loader_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_MODHDR = 3'd1,
        ST_P0     = 3'd2,
        ST_P1     = 3'd3,
        ST_CMD    = 3'd4,
        ST_DATA   = 3'd5,
        ST_DRAIN  = 3'd6
    } load_state_t;

    localparam logic [15:0] DEFAULT_LOAD_ETHERTYPE = 16'h88B5;

    localparam int CMD_ADDR_HI  = 63;
    localparam int CMD_ADDR_LO  = 32;
    localparam int CMD_CNT_HI   = 31;
    localparam int CMD_CNT_LO   = 16;
    localparam int ETYPE_HI     = 31;
    localparam int ETYPE_LO     = 16;

    // Word index of the current word inside the packet, saturating past the CMD word
    localparam int FRM_IDX_W = 4;
    localparam logic [FRM_IDX_W-1:0] FRM_IDX_P0  = 4'd0;
    localparam logic [FRM_IDX_W-1:0] FRM_IDX_P1  = 4'd1;
    localparam logic [FRM_IDX_W-1:0] FRM_IDX_MAX = 4'd15;

    // A nonzero ctrl marks a module header before P0, and the EOP word after it
    function automatic logic is_ctrl_word(input logic [7:0] ctrl);
        return (ctrl != 8'h00);
    endfunction

endpackage

// File: rtl/pkt_mem_loader_frame_tracker.sv
// pkt_frame_tracker: follows module-header / P0 / EOP framing of the snooped stream
// and classifies the word currently on the bus (header flag, word index, EOP flag).
module pkt_frame_tracker
    import pkt_mem_loader_pkg::*;
#(
    parameter int CTRL_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_wr,
    input  logic [CTRL_WIDTH-1:0] in_ctrl,
    output logic                 is_hdr,
    output logic                 is_eop,
    output logic [FRM_IDX_W-1:0] word_idx
);

    logic                 in_pkt_r;
    logic                 in_pkt_s;
    logic [FRM_IDX_W-1:0] cnt_r;
    logic [FRM_IDX_W-1:0] cnt_s;

    // Classify the current word and compute the framing state after it
    always_comb begin
        is_hdr   = 1'b0;
        is_eop   = 1'b0;
        word_idx = FRM_IDX_P0;
        in_pkt_s = in_pkt_r;
        cnt_s    = cnt_r;
        if (in_wr) begin
            if (!in_pkt_r) begin
                if (is_ctrl_word(in_ctrl)) begin
                    is_hdr = 1'b1;
                end else begin
                    in_pkt_s = 1'b1;
                    cnt_s    = FRM_IDX_P1;
                end
            end else begin
                word_idx = cnt_r;
                if (is_ctrl_word(in_ctrl)) begin
                    is_eop   = 1'b1;
                    in_pkt_s = 1'b0;
                    cnt_s    = FRM_IDX_P0;
                end else if (cnt_r != FRM_IDX_MAX) begin
                    cnt_s = cnt_r + 4'd1;
                end else begin
                    cnt_s = cnt_r;
                end
            end
        end else begin
            in_pkt_s = in_pkt_r;
        end
    end

    // Framing state register
    always_ff @(posedge clk) begin
        if (reset) begin
            in_pkt_r <= 1'b0;
            cnt_r    <= FRM_IDX_P0;
        end else begin
            in_pkt_r <= in_pkt_s;
            cnt_r    <= cnt_s;
        end
    end

endmodule

// File: rtl/pkt_mem_loader.sv
// Turns tagged "program load" packets on the snooped stream into core memory writes.
// Optional checksum trailer check is built when PKT_MEM_LOADER_CSUM_EN is defined.
module pkt_mem_loader
    import pkt_mem_loader_pkg::*;
#(
    parameter int          DATA_WIDTH     = 64,
    parameter int          CTRL_WIDTH     = DATA_WIDTH / 8,
    parameter int          MEM_ADDR_WIDTH = 10,
    parameter logic [15:0] LOAD_ETHERTYPE = DEFAULT_LOAD_ETHERTYPE
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [DATA_WIDTH-1:0]     in_data,
    input  logic [CTRL_WIDTH-1:0]     in_ctrl,
    input  logic                      in_wr,
    input  logic                      loader_en,
    output logic                      mem_wr,
    output logic [MEM_ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0]     mem_data,
    output logic                      core_hold,
    output logic                      load_done,
    output logic                      load_err,
    output logic [31:0]               words_loaded
);

    load_state_t               state_r, state_s;
    logic [MEM_ADDR_WIDTH-1:0] base_r, base_s;
    logic [15:0]               cnt_n_r, cnt_n_s;
    logic [15:0]               idx_r, idx_s;
    logic                      active_r, active_s;
    logic                      mem_wr_r, mem_wr_s;
    logic [MEM_ADDR_WIDTH-1:0] mem_addr_r, mem_addr_s;
    logic [DATA_WIDTH-1:0]     mem_data_r, mem_data_s;
    logic                      core_hold_r, core_hold_s;
    logic                      load_done_r, load_done_s;
    logic                      load_err_r, load_err_s;
    logic [31:0]               words_loaded_r, words_loaded_s;
    logic                      last_s;
`ifdef PKT_MEM_LOADER_CSUM_EN
    logic [DATA_WIDTH-1:0]     csum_r, csum_s;
    logic                      trailer_s;
    assign trailer_s = (idx_r == cnt_n_r);
`endif

    logic                 frm_hdr_s;
    logic                 frm_eop_s;
    logic [FRM_IDX_W-1:0] frm_idx_s;

    pkt_frame_tracker #(
        .CTRL_WIDTH (CTRL_WIDTH)
    ) u_frame_tracker (
        .clk      (clk),
        .reset    (reset),
        .in_wr    (in_wr),
        .in_ctrl  (in_ctrl),
        .is_hdr   (frm_hdr_s),
        .is_eop   (frm_eop_s),
        .word_idx (frm_idx_s)
    );

    assign last_s = (idx_r == (cnt_n_r - 16'd1));

    // Load FSM: next state and next values of every registered output
    always_comb begin
        state_s        = state_r;
        base_s         = base_r;
        cnt_n_s        = cnt_n_r;
        idx_s          = idx_r;
        active_s       = active_r;
        mem_wr_s       = 1'b0;
        mem_addr_s     = mem_addr_r;
        mem_data_s     = mem_data_r;
        core_hold_s    = core_hold_r;
        load_done_s    = 1'b0;
        load_err_s     = load_err_r;
        words_loaded_s = words_loaded_r;
`ifdef PKT_MEM_LOADER_CSUM_EN
        csum_s         = csum_r;
`endif
        if (in_wr) begin
            case (state_r)
                ST_IDLE, ST_MODHDR: begin
                    if (frm_hdr_s) begin
                        state_s = ST_MODHDR;
                    end else if (frm_idx_s == FRM_IDX_P0) begin
                        state_s = ST_P1;
                    end else begin
                        state_s = ST_IDLE;
                    end
                end
                ST_P1: begin
                    if (frm_eop_s) begin
                        state_s = ST_IDLE;
                    end else if ((frm_idx_s == FRM_IDX_P1) && loader_en &&
                                 (in_data[ETYPE_HI:ETYPE_LO] == LOAD_ETHERTYPE)) begin
                        state_s = ST_CMD;
                    end else begin
                        state_s = ST_DRAIN;
                    end
                end
                ST_CMD: begin
                    base_s     = in_data[CMD_ADDR_LO +: MEM_ADDR_WIDTH];
                    cnt_n_s    = in_data[CMD_CNT_HI:CMD_CNT_LO];
                    idx_s      = 16'd0;
                    load_err_s = 1'b0;
`ifdef PKT_MEM_LOADER_CSUM_EN
                    csum_s     = {DATA_WIDTH{1'b0}};
`endif
                    if (frm_eop_s) begin
                        load_err_s  = 1'b1;
                        core_hold_s = 1'b0;
                        active_s    = 1'b0;
                        state_s     = ST_IDLE;
                    end else begin
                        core_hold_s = 1'b1;
                        active_s    = 1'b1;
`ifdef PKT_MEM_LOADER_CSUM_EN
                        // N == 0 still expects a trailer, so always go through DATA
                        state_s     = ST_DATA;
`else
                        if (in_data[CMD_CNT_HI:CMD_CNT_LO] == 16'd0) begin
                            state_s = ST_DRAIN;
                        end else begin
                            state_s = ST_DATA;
                        end
`endif
                    end
                end
                ST_DATA: begin
`ifdef PKT_MEM_LOADER_CSUM_EN
                    if (!trailer_s) begin
                        mem_wr_s       = 1'b1;
                        mem_addr_s     = base_r + idx_r[MEM_ADDR_WIDTH-1:0];
                        mem_data_s     = in_data;
                        idx_s          = idx_r + 16'd1;
                        words_loaded_s = words_loaded_r + 32'd1;
                        csum_s         = csum_r ^ in_data;
                        if (frm_eop_s) begin
                            load_err_s  = 1'b1;
                            load_done_s = 1'b1;
                            core_hold_s = 1'b0;
                            active_s    = 1'b0;
                            state_s     = ST_IDLE;
                        end else begin
                            state_s = ST_DATA;
                        end
                    end else begin
                        if (in_data != csum_r) begin
                            load_err_s = 1'b1;
                        end else begin
                            load_err_s = load_err_r;
                        end
                        if (frm_eop_s) begin
                            load_done_s = 1'b1;
                            core_hold_s = 1'b0;
                            active_s    = 1'b0;
                            state_s     = ST_IDLE;
                        end else begin
                            state_s = ST_DRAIN;
                        end
                    end
`else
                    mem_wr_s       = 1'b1;
                    mem_addr_s     = base_r + idx_r[MEM_ADDR_WIDTH-1:0];
                    mem_data_s     = in_data;
                    idx_s          = idx_r + 16'd1;
                    words_loaded_s = words_loaded_r + 32'd1;
                    if (frm_eop_s) begin
                        if (!last_s) begin
                            load_err_s = 1'b1;
                        end else begin
                            load_err_s = load_err_r;
                        end
                        load_done_s = 1'b1;
                        core_hold_s = 1'b0;
                        active_s    = 1'b0;
                        state_s     = ST_IDLE;
                    end else if (last_s) begin
                        state_s = ST_DRAIN;
                    end else begin
                        state_s = ST_DATA;
                    end
`endif
                end
                ST_DRAIN: begin
                    if (frm_eop_s) begin
                        state_s = ST_IDLE;
                        if (active_r) begin
                            load_done_s = 1'b1;
                            core_hold_s = 1'b0;
                            active_s    = 1'b0;
                        end else begin
                            active_s = 1'b0;
                        end
                    end else begin
                        state_s = ST_DRAIN;
                    end
                end
                default: begin
                    state_s = ST_IDLE;
                end
            endcase
        end else begin
            state_s = state_r;
        end
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r        <= ST_IDLE;
            base_r         <= {MEM_ADDR_WIDTH{1'b0}};
            cnt_n_r        <= 16'd0;
            idx_r          <= 16'd0;
            active_r       <= 1'b0;
            mem_wr_r       <= 1'b0;
            mem_addr_r     <= {MEM_ADDR_WIDTH{1'b0}};
            mem_data_r     <= {DATA_WIDTH{1'b0}};
            core_hold_r    <= 1'b0;
            load_done_r    <= 1'b0;
            load_err_r     <= 1'b0;
            words_loaded_r <= 32'd0;
`ifdef PKT_MEM_LOADER_CSUM_EN
            csum_r         <= {DATA_WIDTH{1'b0}};
`endif
        end else begin
            state_r        <= state_s;
            base_r         <= base_s;
            cnt_n_r        <= cnt_n_s;
            idx_r          <= idx_s;
            active_r       <= active_s;
            mem_wr_r       <= mem_wr_s;
            mem_addr_r     <= mem_addr_s;
            mem_data_r     <= mem_data_s;
            core_hold_r    <= core_hold_s;
            load_done_r    <= load_done_s;
            load_err_r     <= load_err_s;
            words_loaded_r <= words_loaded_s;
`ifdef PKT_MEM_LOADER_CSUM_EN
            csum_r         <= csum_s;
`endif
        end
    end

    assign mem_wr       = mem_wr_r;
    assign mem_addr     = mem_addr_r;
    assign mem_data     = mem_data_r;
    assign core_hold    = core_hold_r;
    assign load_done    = load_done_r;
    assign load_err     = load_err_r;
    assign words_loaded = words_loaded_r;

endmodule
